neighbour_sum_rule_pipe: RTL and testbench
==========================================

// Module: neighbour_sum_rule_pipe
// PURPOSE
// - Stage directly downstream of the 2-bit->3-bit partial neighbour adders in the Life cell-update path.
// - Merges two 3-bit partial sums (4 neighbours each) into a 4-bit neighbour count.
// - Applies the Conway B3/S23 rule and streams the next cell state out over valid/ready.
// - Also reports per-generation live population and a sticky range-error flag.
// PARAMETERS
// - POP_WIDTH  16  width of population counter; saturates at 2**POP_WIDTH-1
// PORTS
// - clk            in   1          clock, all state on rising edge
// - rst_n          in   1          asynchronous, active-low reset
// - in_valid       in   1          input beat valid
// - in_ready       out  1          stage can accept beat
// - in_alive       in   1          current state of centre cell
// - in_sum_a       in   3          partial neighbour sum, legal 0..4
// - in_sum_b       in   3          partial neighbour sum, legal 0..4
// - in_last        in   1          last cell of current generation
// - out_valid      out  1          output beat valid
// - out_ready      in   1          downstream accepts beat
// - out_alive      out  1          next state of cell
// - out_count      out  4          merged neighbour count (debug/visibility)
// - out_last       out  1          in_last delayed with its beat
// - pop_valid      out  1          1-cycle pulse: gen_population updated
// - gen_population out  POP_WIDTH  live cells in last completed generation
// - range_err      out  1          sticky: a partial sum >4 was accepted
// BEHAVIOUR
// - Reset (async on rst_n low): both stage valids, out_*, pop_valid, gen_population, pop counter, range_err all 0.
// - Input accepted on in_valid && in_ready; output accepted on out_valid && out_ready.
// - Stage S1 registers {alive, count=in_sum_a+in_sum_b (zero-extended to 4 bits, no wrap; max 14), last}.
// - Stage S2 registers the rule result: next = (count==3) | (alive & count==2). Out-of-range counts follow the same rule (they evaluate dead).
// - Latency: 2 cycles from input acceptance to out_valid when unstalled; throughput 1 beat/cycle.
// - Backpressure: a stage loads when it is empty or its content leaves the same cycle; in_ready = !s1_valid | s1_advances.
//   - No combinational path from in_valid to out_valid.
//   - in_ready may depend combinationally on out_ready.
// - A held output beat (out_valid & !out_ready) keeps out_alive/out_count/out_last stable. No beat is dropped or duplicated.
// - Population: internal counter += out_alive on each accepted output beat; it saturates, never wraps.
//   - On accepted beat with out_last: gen_population <= counter + out_alive (saturated); pop_valid=1 next cycle only; counter <= 0 the same edge.
//   - gen_population holds its value until the next out_last beat.
// - range_err set on accepted input with in_sum_a>4 or in_sum_b>4; cleared only by reset.
// - Reset mid-stream: in-flight beats discarded, partial population lost; first beat after release starts a fresh generation.
// STRUCTURE
// - conway_pkg:
//   - typedef packed cell_beat_t {alive, count[3:0], last}
//   - localparams MAX_PARTIAL_SUM=4, BIRTH_COUNT=3, SURVIVE_MIN=2, SURVIVE_MAX=3
// - Sub-module cell_rule_eval: combinational (alive, count[3:0]) -> next_alive, instantiated in S2.
// - Top holds the two pipeline registers, handshake logic, population counter and error flag.
// TESTING
// - Rule table, out_ready=1:
//   - alive=1 with 3+0, 1+1, 2+2 -> out_alive 1,1,0.
//   - alive=0 with 2+1, 1+1 -> 1,0.
//   - Each output exactly 2 cycles after acceptance.
// - Stream 8 beats back-to-back, out_ready=1: in_ready stays 1, outputs in order, no bubbles.
// - Backpressure: out_ready=0 for 5 cycles mid-stream.
//   - in_ready falls after S1/S2 fill; held out_* stable.
//   - After release all beats emerge once, in order.
// - Population: generation of 6 beats with 4 next-alive, last on 6th.
//   - pop_valid pulses once; gen_population=4.
//   - Next generation of 0 alive -> gen_population=0.
// - Saturation, POP_WIDTH=2: 5 live beats then last -> gen_population=3.
// - Range/reset:
//   - in_sum_a=5 accepted -> range_err=1 stays set.
//   - rst_n low mid-stream -> out_valid=0, range_err=0, gen_population=0 immediately.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and rule constants for the Life cell-update pipeline.
// Holds the inter-stage beat struct and the B3/S23 rule thresholds.
package conway_pkg;

    localparam int MAX_PARTIAL_SUM = 4;
    localparam int BIRTH_COUNT     = 3;
    localparam int SURVIVE_MIN     = 2;
    localparam int SURVIVE_MAX     = 3;

    typedef struct packed {
        logic       alive;
        logic [3:0] count;
        logic       last;
    } cell_beat_t;

endpackage

// File: rtl/cell_rule_eval.sv
// Combinational Conway B3/S23 rule: (alive, count) -> next_alive.
// Ports: i_alive, i_count[3:0] in; o_next_alive out.
module cell_rule_eval
    import conway_pkg::*;
(
    input  logic       i_alive,
    input  logic [3:0] i_count,
    output logic       o_next_alive
);

    logic w_birth;
    logic w_survive;

    // Counts above 8 cannot match either term, so they evaluate dead.
    assign w_birth   = (i_count == 4'(BIRTH_COUNT));
    assign w_survive = i_alive
                     & (i_count >= 4'(SURVIVE_MIN))
                     & (i_count <= 4'(SURVIVE_MAX));

    assign o_next_alive = w_birth | w_survive;

endmodule

// File: rtl/neighbour_sum_rule_pipe.sv
// Two-stage valid/ready pipe: merges partial neighbour sums, applies B3/S23.
// Ports: in_* beat + handshake, out_* beat + handshake, pop_valid,
// gen_population (per-generation live count), range_err (sticky).
module neighbour_sum_rule_pipe
    import conway_pkg::*;
#(
    parameter int POP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_alive,
    input  logic [2:0]           in_sum_a,
    input  logic [2:0]           in_sum_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_alive,
    output logic [3:0]           out_count,
    output logic                 out_last,
    output logic                 pop_valid,
    output logic [POP_WIDTH-1:0] gen_population,
    output logic                 range_err
);

    localparam logic [POP_WIDTH-1:0] POP_MAX = '1;

    logic                 r_s1_valid;
    cell_beat_t           r_s1;
    logic                 r_s2_valid;
    cell_beat_t           r_s2;
    logic [POP_WIDTH-1:0] r_pop_cnt;
    logic [POP_WIDTH-1:0] r_gen_pop;
    logic                 r_pop_valid;
    logic                 r_range_err;

    logic                 w_s2_load;
    logic                 w_s1_adv;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [3:0]           w_sum;
    logic                 w_next_alive;
    logic                 w_bad_sum;
    logic [POP_WIDTH-1:0] w_pop_next;

    // S2 can take a beat when empty or when its beat leaves this cycle.
    assign w_s2_load  = !r_s2_valid | out_ready;
    assign w_s1_adv   = r_s1_valid & w_s2_load;
    assign in_ready   = !r_s1_valid | w_s1_adv;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_s2_valid & out_ready;

    assign w_sum = {1'b0, in_sum_a} + {1'b0, in_sum_b};

    assign w_bad_sum = (in_sum_a > 3'(MAX_PARTIAL_SUM))
                     | (in_sum_b > 3'(MAX_PARTIAL_SUM));

    cell_rule_eval u_rule (
        .i_alive      (r_s1.alive),
        .i_count      (r_s1.count),
        .o_next_alive (w_next_alive)
    );

    // Saturating add of the leaving beat's state to the running count.
    always_comb begin
        w_pop_next = r_pop_cnt;
        if (r_s2.alive && r_pop_cnt != POP_MAX) begin
            w_pop_next = r_pop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1 <= '{alive: in_alive,
                          count: w_sum,
                          last:  in_last};
            end
        end
    end

    // S2 stores the rule result in place of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2 <= '{alive: w_next_alive,
                          count: r_s1.count,
                          last:  r_s1.last};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_cnt   <= '0;
            r_gen_pop   <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            if (w_out_fire) begin
                if (r_s2.last) begin
                    r_gen_pop   <= w_pop_next;
                    r_pop_valid <= 1'b1;
                    r_pop_cnt   <= '0;
                end else begin
                    r_pop_cnt <= w_pop_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (w_in_fire && w_bad_sum) begin
            r_range_err <= 1'b1;
        end
    end

    assign out_valid      = r_s2_valid;
    assign out_alive      = r_s2.alive;
    assign out_count      = r_s2.count;
    assign out_last       = r_s2.last;
    assign pop_valid      = r_pop_valid;
    assign gen_population = r_gen_pop;
    assign range_err      = r_range_err;

endmodule

// File: tb/tb_neighbour_sum_rule_pipe.sv
// Self-checking bench for neighbour_sum_rule_pipe with a queue-based
// reference model; a second instance with POP_WIDTH=2 covers saturation.
module tb_neighbour_sum_rule_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_alive = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] in_sum_a = '0;
    logic [2:0] in_sum_b = '0;

    logic        in_ready, out_valid, out_alive, out_last;
    logic        pop_valid, range_err;
    logic [3:0]  out_count;
    logic [15:0] gen_population;

    logic        s_in_ready, s_out_valid, s_out_alive, s_out_last;
    logic        s_pop_valid, s_range_err;
    logic [3:0]  s_out_count;
    logic [1:0]  s_gen_population;

    always #5 clk = ~clk;

    neighbour_sum_rule_pipe #(.POP_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alive(in_alive), .in_sum_a(in_sum_a),
        .in_sum_b(in_sum_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alive(out_alive), .out_count(out_count),
        .out_last(out_last), .pop_valid(pop_valid),
        .gen_population(gen_population), .range_err(range_err)
    );

    neighbour_sum_rule_pipe #(.POP_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_alive(in_alive), .in_sum_a(in_sum_a),
        .in_sum_b(in_sum_b), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_alive(s_out_alive), .out_count(s_out_count),
        .out_last(s_out_last), .pop_valid(s_pop_valid),
        .gen_population(s_gen_population), .range_err(s_range_err)
    );

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];
    int popm = 0;
    int exp_gen = 0;

    // Reference: {next_alive, count, last} from the B3/S23 rule.
    function automatic logic [5:0] model_beat(logic a, logic [2:0] sa,
                                              logic [2:0] sb, logic l);
        int c;
        logic n;
        c = int'(sa) + int'(sb);
        n = (c == 3) || (a && c == 2);
        return {n, 4'(c), l};
    endfunction

    function automatic int sat(int v, int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic take(output logic [5:0] e, output bit ok);
        ok = exp_q.size() > 0;
        e = '0;
        if (ok) begin
            e = exp_q.pop_front();
            popm += int'(e[5]);
            if (e[0]) begin
                exp_gen = popm;
                popm = 0;
            end
        end
    endtask

    // Drives one cycle and reports what crossed the ports.
    task automatic step(input logic v, input logic a,
                        input logic [2:0] sa, input logic [2:0] sb,
                        input logic l, input logic ordy,
                        output logic fi, output logic ov,
                        output logic fo, output logic [5:0] ob,
                        output logic pv);
        in_valid = v; in_alive = a; in_sum_a = sa;
        in_sum_b = sb; in_last = l; out_ready = ordy;
        #1;
        fi = in_valid && in_ready;
        ov = out_valid;
        fo = out_valid && out_ready;
        ob = {out_alive, out_count, out_last};
        pv = pop_valid;
        if (fi) exp_q.push_back(model_beat(a, sa, sb, l));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++;
        if (pop_valid !== 1'b0) begin
            errors++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid);
        end
        checks++;
        if (gen_population !== 16'd0) begin
            errors++;
            $display("FAIL reset_gen_pop got=%0d exp=0", gen_population);
        end
        checks++;
        if (range_err !== 1'b0) begin
            errors++; $display("FAIL reset_range_err got=%b exp=0", range_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rule_table();
        int ta[5] = '{1, 1, 1, 0, 0};
        int sa[5] = '{3, 1, 2, 2, 1};
        int sb[5] = '{0, 1, 2, 1, 1};
        int te[5] = '{1, 1, 0, 1, 0};
        logic fi, ov, fo, pv;
        logic [5:0] ob, e;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'(ta[i]), 3'(sa[i]), 3'(sb[i]), i == 4, 1'b1,
                 fi, ov, fo, ob, pv);
            checks++;
            if (fi !== 1'b1) begin
                errors++; $display("FAIL rule_accept[%0d] got=%b exp=1", i, fi);
            end
            step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, fi, ov, fo, ob, pv);
            checks++;
            if (ov !== 1'b0) begin
                errors++; $display("FAIL rule_lat1[%0d] got=%b exp=0", i, ov);
            end
            step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, fi, ov, fo, ob, pv);
            checks++;
            if (fo !== 1'b1) begin
                errors++; $display("FAIL rule_lat2[%0d] got=%b exp=1", i, fo);
            end else begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e || ob[5] !== 1'(te[i])) begin
                    errors++;
                    $display("FAIL rule_out[%0d] got=%h exp=%h", i, ob, e);
                end
            end
        end
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, fi, ov, fo, ob, pv);
        checks++;
        if (gen_population !== 16'(exp_gen) || exp_gen != 3) begin
            errors++;
            $display("FAIL rule_pop got=%0d exp=3", gen_population);
        end
    endtask

    task automatic test_back_to_back();
        logic fi, ov, fo, pv;
        logic [5:0] ob, e;
        bit ok;
        for (int k = 0; k < 12; k++) begin
            step(k < 8, 1'($urandom), 3'($urandom_range(4, 0)),
                 3'($urandom_range(4, 0)), k == 7, 1'b1,
                 fi, ov, fo, ob, pv);
            if (k < 8) begin
                checks++;
                if (fi !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, fi);
                end
            end
            checks++;
            if (fo !== (k >= 2 && k < 10)) begin
                errors++; $display("FAIL b2b_bubble[%0d] got=%b", k, fo);
            end
            if (fo) begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e) begin
                    errors++; $display("FAIL b2b_out[%0d] got=%h exp=%h", k, ob, e);
                end
            end
        end
        checks++;
        if (gen_population !== 16'(exp_gen)) begin
            errors++;
            $display("FAIL b2b_pop got=%0d exp=%0d", gen_population, exp_gen);
        end
    endtask

    task automatic test_backpressure();
        logic fi, ov, fo, pv;
        logic [5:0] ob, e, held;
        bit ok;
        int nsent = 0;
        int k = 0;
        held = '0;
        while (k < 40 && !(nsent == 12 && exp_q.size() == 0 && k > 9)) begin
            step(nsent < 12, 1'($urandom), 3'($urandom_range(4, 0)),
                 3'($urandom_range(4, 0)), nsent == 11,
                 !(k >= 4 && k < 9), fi, ov, fo, ob, pv);
            if (fi) nsent++;
            if (k == 4) held = ob;
            if (k >= 5 && k < 9) begin
                checks++;
                if (ov !== 1'b1 || ob !== held) begin
                    errors++;
                    $display("FAIL bp_hold[%0d] got=%h exp=%h", k, ob, held);
                end
            end
            if (k == 8) begin
                checks++;
                if (fi !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready got=%b exp=0", fi);
                end
            end
            if (fo) begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e) begin
                    errors++; $display("FAIL bp_out[%0d] got=%h exp=%h", k, ob, e);
                end
            end
            k++;
        end
        checks++;
        if (nsent != 12 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain sent=%0d left=%0d exp=12/0",
                     nsent, exp_q.size());
        end
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, fi, ov, fo, ob, pv);
        checks++;
        if (ov !== 1'b0 || gen_population !== 16'(exp_gen)) begin
            errors++;
            $display("FAIL bp_tail valid=%b pop=%0d exp=0/%0d",
                     ov, gen_population, exp_gen);
        end
    endtask

    task automatic test_population();
        int ta[9] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};
        int sa[9] = '{2, 1, 0, 3, 4, 3, 0, 1, 4};
        int sb[9] = '{1, 1, 0, 0, 4, 0, 0, 0, 4};
        logic fi, ov, fo, pv;
        logic [5:0] ob, e;
        bit ok;
        int idx = 0;
        int j;
        int pulses = 0;
        logic [15:0] g[$];
        logic [1:0] gs[$];
        for (int k = 0; k < 16; k++) begin
            j = (idx < 9) ? idx : 0;
            step(idx < 9, 1'(ta[j]), 3'(sa[j]), 3'(sb[j]),
                 (j == 5 || j == 8), 1'b1, fi, ov, fo, ob, pv);
            if (fi) idx++;
            if (fo) begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e) begin
                    errors++; $display("FAIL pop_out[%0d] got=%h exp=%h", k, ob, e);
                end
            end
            if (pv) begin
                pulses++;
                g.push_back(gen_population);
                gs.push_back(s_gen_population);
            end
        end
        checks++;
        if (pulses != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL pop_pulses got=%0d exp=2 left=%0d", pulses, exp_q.size());
        end
        if (g.size() == 2) begin
            checks++;
            if (g[0] !== 16'd4 || gs[0] !== 2'(sat(4, 2))) begin
                errors++;
                $display("FAIL pop_gen1 got=%0d/%0d exp=4/3", g[0], gs[0]);
            end
            checks++;
            if (g[1] !== 16'd0 || gs[1] !== 2'd0) begin
                errors++;
                $display("FAIL pop_gen2 got=%0d/%0d exp=0/0", g[1], gs[1]);
            end
        end
    endtask

    task automatic test_saturation();
        logic fi, ov, fo, pv;
        logic [5:0] ob, e;
        bit ok;
        int idx = 0;
        int pulses = 0;
        logic [15:0] g;
        logic [1:0] gs;
        g = '0;
        gs = '0;
        for (int k = 0; k < 12; k++) begin
            if (idx < 5)
                step(1'b1, 1'b0, 3'd2, 3'd1, 1'b0, 1'b1, fi, ov, fo, ob, pv);
            else
                step(idx < 6, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1,
                     fi, ov, fo, ob, pv);
            if (fi) idx++;
            if (fo) begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e) begin
                    errors++; $display("FAIL sat_out[%0d] got=%h exp=%h", k, ob, e);
                end
            end
            if (pv) begin
                pulses++;
                g = gen_population;
                gs = s_gen_population;
            end
        end
        checks++;
        if (pulses != 1 || gs !== 2'd3 || g !== 16'd5
            || g !== 16'(exp_gen) || gs !== 2'(sat(exp_gen, 2))) begin
            errors++;
            $display("FAIL sat_pop pulses=%0d got=%0d/%0d exp=1 5/3",
                     pulses, g, gs);
        end
    endtask

    task automatic test_range_reset();
        logic fi, ov, fo, pv;
        logic [5:0] ob, e;
        bit ok;
        bit first = 1'b1;
        int pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)
                step(1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 1'b1, fi, ov, fo, ob, pv);
            else
                step(k < 4, 1'($urandom), 3'($urandom_range(4, 0)),
                     3'($urandom_range(4, 0)), 1'b0, 1'b1,
                     fi, ov, fo, ob, pv);
            if (k == 0) begin
                checks++;
                if (range_err !== 1'b1) begin
                    errors++; $display("FAIL range_set got=%b exp=1", range_err);
                end
            end
            if (fo) begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e || (first && ob[5:1] !== 5'b0_0101)) begin
                    errors++; $display("FAIL range_out[%0d] got=%h exp=%h", k, ob, e);
                end
                first = 1'b0;
            end
        end
        checks++;
        if (range_err !== 1'b1) begin
            errors++; $display("FAIL range_sticky got=%b exp=1", range_err);
        end
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 3'd2, 3'd1, 1'b0, 1'b0, fi, ov, fo, ob, pv);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        popm = 0;
        checks++;
        if (out_valid !== 1'b0 || range_err !== 1'b0
            || gen_population !== 16'd0 || s_gen_population !== 2'd0
            || pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid=%b err=%b pop=%0d/%0d exp=0",
                     out_valid, range_err, gen_population, s_gen_population);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k == 0)
                step(1'b1, 1'b0, 3'd2, 3'd1, 1'b0, 1'b1, fi, ov, fo, ob, pv);
            else
                step(k == 1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1,
                     fi, ov, fo, ob, pv);
            if (fo) begin
                take(e, ok);
                checks++;
                if (!ok || ob !== e) begin
                    errors++; $display("FAIL fresh_out[%0d] got=%h exp=%h", k, ob, e);
                end
            end
            if (pv) pulses++;
        end
        checks++;
        if (pulses != 1 || gen_population !== 16'd1 || exp_gen != 1) begin
            errors++;
            $display("FAIL fresh_pop pulses=%0d got=%0d exp=1/1",
                     pulses, gen_population);
        end
    endtask

    initial begin
        test_reset();
        test_rule_table();
        test_back_to_back();
        test_backpressure();
        test_population();
        test_saturation();
        test_range_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
